// File: rtl/programmable_prescaler_if.sv
// Control and status bundle for programmable_prescaler.
// The master drives the configuration strobes; the slave (the prescaler) returns registered outputs.
interface programmable_prescaler_if #(
    parameter int WIDTH = 32,
    parameter int OUT_W = 8,
    parameter int DIV_W = 16,
    parameter int TAP_W = 5
) ();
    logic             enable;
    logic             load;
    logic             mode;
    logic [TAP_W-1:0] tap_sel;
    logic [DIV_W-1:0] div_n;
    logic [OUT_W-1:0] prescaled;
    logic             div_out;
    logic             tick;
    logic [WIDTH-1:0] count;

    modport master (
        output enable, load, mode, tap_sel, div_n,
        input  prescaled, div_out, tick, count
    );

    modport slave (
        input  enable, load, mode, tap_sel, div_n,
        output prescaled, div_out, tick, count
    );
endinterface

// File: rtl/programmable_prescaler.sv
// Free-running counter with a selectable tap window plus a divide-by-N tick/toggle engine.
// Everything runs on clkC; outputs are registered and nothing derived is used as a clock.
module programmable_prescaler #(
    parameter int WIDTH   = 32,
    parameter int OUT_W   = 8,
    parameter int DIV_W   = 16,
    parameter int TAP_W   = 5,
    parameter int TAP_RST = 22
) (
    input logic                     clkC,
    input logic                     reset,
    programmable_prescaler_if.slave bus
);

    localparam logic [TAP_W-1:0] TAP_MAX  = TAP_W'(WIDTH - 1);
    localparam logic [TAP_W-1:0] TAP_INIT = TAP_W'(TAP_RST);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] count_q,     count_d;
    logic [DIV_W-1:0] div_cnt_q,   div_cnt_d;
    logic             div_out_q,   div_out_d;
    logic             tick_q,      tick_d;
    logic [OUT_W-1:0] prescaled_q, prescaled_d;
    logic             mode_q,      mode_d;
    logic [TAP_W-1:0] tap_sel_q,   tap_sel_d;
    logic [DIV_W-1:0] div_n_q,     div_n_d;
    logic             div_wrap_s;

    // Next-state for counter, divider, shadow registers and the output window.
    always_comb begin
        count_d     = count_q;
        div_cnt_d   = div_cnt_q;
        div_out_d   = div_out_q;
        tick_d      = 1'b0;
        mode_d      = mode_q;
        tap_sel_d   = tap_sel_q;
        div_n_d     = div_n_q;
        prescaled_d = prescaled_q;
        div_wrap_s  = (div_n_q != DIV_ZERO) && (div_cnt_q == (div_n_q - DIV_ONE));

        if (bus.enable) begin
            count_d = count_q + CNT_ONE;
        end else begin
            count_d = count_q;
        end

        if (bus.load) begin
            mode_d    = bus.mode;
            tap_sel_d = (bus.tap_sel > TAP_MAX) ? TAP_MAX : bus.tap_sel;
            div_n_d   = bus.div_n;
            div_cnt_d = DIV_ZERO;
        end else if (bus.enable) begin
            // The divider keeps running in tap mode; only the tick/toggle is mode-gated.
            if (div_n_q == DIV_ZERO) begin
                div_cnt_d = DIV_ZERO;
            end else if (div_wrap_s) begin
                div_cnt_d = DIV_ZERO;
                if (mode_q) begin
                    tick_d    = 1'b1;
                    div_out_d = ~div_out_q;
                end else begin
                    tick_d    = 1'b0;
                end
            end else begin
                div_cnt_d = div_cnt_q + DIV_ONE;
            end
        end else begin
            div_cnt_d = div_cnt_q;
        end

        if (mode_q) begin
            prescaled_d = OUT_W'(div_out_d);
        end else begin
            prescaled_d = OUT_W'(count_q >> tap_sel_q);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clkC) begin
        if (reset) begin
            count_q     <= {WIDTH{1'b0}};
            div_cnt_q   <= DIV_ZERO;
            div_out_q   <= 1'b0;
            tick_q      <= 1'b0;
            prescaled_q <= {OUT_W{1'b0}};
            mode_q      <= 1'b0;
            tap_sel_q   <= TAP_INIT;
            div_n_q     <= DIV_ONE;
        end else begin
            count_q     <= count_d;
            div_cnt_q   <= div_cnt_d;
            div_out_q   <= div_out_d;
            tick_q      <= tick_d;
            prescaled_q <= prescaled_d;
            mode_q      <= mode_d;
            tap_sel_q   <= tap_sel_d;
            div_n_q     <= div_n_d;
        end
    end

    assign bus.count     = count_q;
    assign bus.div_out   = div_out_q;
    assign bus.tick      = tick_q;
    assign bus.prescaled = prescaled_q;

endmodule

// File: tb/tb_programmable_prescaler.sv
// Directed bench for programmable_prescaler: a default-sized instance plus a
// narrow instance (WIDTH=10) where tap saturation and the top bits are reachable.
module tb_programmable_prescaler;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    programmable_prescaler_if #(.WIDTH(32), .OUT_W(8), .DIV_W(16), .TAP_W(6)) bus ();
    programmable_prescaler_if #(.WIDTH(10), .OUT_W(4), .DIV_W(16), .TAP_W(4)) bus2 ();

    programmable_prescaler #(.WIDTH(32), .OUT_W(8), .DIV_W(16), .TAP_W(6), .TAP_RST(22)) dut (
        .clkC(clk), .reset(reset), .bus(bus)
    );
    programmable_prescaler #(.WIDTH(10), .OUT_W(4), .DIV_W(16), .TAP_W(4), .TAP_RST(2)) dut2 (
        .clkC(clk), .reset(reset), .bus(bus2)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_cnt  = 32'd0;
    logic [9:0]  exp_cnt2 = 10'd0;
    logic        exp_div  = 1'b0;

    function automatic logic [7:0] win(input logic [31:0] c, input int t);
        int s;
        s = (t > 31) ? 31 : t;
        return 8'(c >> s);
    endfunction

    function automatic logic [3:0] win2(input logic [9:0] c, input int t);
        int s;
        s = (t > 9) ? 9 : t;
        return 4'(c >> s);
    endfunction

    // One clock, from negedge to negedge, updating the bench's count model.
    task automatic step();
        logic en1, en2, r;
        en1 = bus.enable;
        en2 = bus2.enable;
        r   = reset;
        @(negedge clk);
        if (r) begin
            exp_cnt  = 32'd0;
            exp_cnt2 = 10'd0;
        end else begin
            if (en1) exp_cnt  = exp_cnt + 32'd1;
            if (en2) exp_cnt2 = exp_cnt2 + 10'd1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.enable = 1'b0; bus.load = 1'b0; bus.mode = 1'b0; bus.tap_sel = 6'd0; bus.div_n = 16'd0;
        bus2.enable = 1'b0; bus2.load = 1'b0; bus2.mode = 1'b0; bus2.tap_sel = 4'd0; bus2.div_n = 16'd0;
        step(); step();
        reset = 1'b0;
        n_checks++; if (bus.count !== 32'd0) $display("FAIL reset_count: got %h want 0", bus.count); else n_pass++;
        n_checks++; if (bus.prescaled !== 8'd0) $display("FAIL reset_prescaled: got %h want 0", bus.prescaled); else n_pass++;
        n_checks++; if (bus.tick !== 1'b0 || bus.div_out !== 1'b0) $display("FAIL reset_tick_div: got %b%b want 00", bus.tick, bus.div_out); else n_pass++;
        n_checks++; if (dut.mode_q !== 1'b0 || dut.tap_sel_q !== 6'd22 || dut.div_n_q !== 16'd1)
            $display("FAIL reset_shadow: got %b/%0d/%0d want 0/22/1", dut.mode_q, dut.tap_sel_q, dut.div_n_q); else n_pass++;
        n_checks++; if (bus2.count !== 10'd0 || bus2.prescaled !== 4'd0) $display("FAIL reset_small: got %h/%h want 0/0", bus2.count, bus2.prescaled); else n_pass++;
    endtask

    task automatic test_default_tap();
        int ticks = 0;
        bus.enable = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (bus.tick !== 1'b0) ticks++;
        end
        n_checks++; if (ticks != 0) $display("FAIL default_tick: got %0d ticks want 0", ticks); else n_pass++;
        n_checks++; if (bus.count !== 32'd2000) $display("FAIL default_count: got %0d want 2000", bus.count); else n_pass++;
        n_checks++; if (bus.prescaled !== 8'd0) $display("FAIL default_prescaled: got %h want 0", bus.prescaled); else n_pass++;
    endtask

    task automatic test_tap_window();
        int taps[2] = '{0, 3};
        int lens[2] = '{300, 60};
        logic [31:0] prev;
        for (int k = 0; k < 2; k++) begin
            bus.load = 1'b1; bus.mode = 1'b0; bus.tap_sel = 6'(taps[k]); bus.div_n = 16'd1;
            step();
            bus.load = 1'b0;
            for (int i = 0; i < lens[k]; i++) begin
                prev = exp_cnt;
                step();
                n_checks++; if (bus.prescaled !== win(prev, taps[k]) || bus.count !== exp_cnt)
                    $display("FAIL tap%0d_window: got %h/%h want %h/%h", taps[k], bus.prescaled, bus.count, win(prev, taps[k]), exp_cnt);
                else n_pass++;
                n_checks++; if (bus.tick !== 1'b0) $display("FAIL tap%0d_tick: got %b want 0", taps[k], bus.tick); else n_pass++;
            end
        end
    endtask

    task automatic test_saturation();
        int taps[2] = '{15, 7};
        int lens[2] = '{700, 400};
        logic [9:0] prev;
        bus2.enable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus2.load = 1'b1; bus2.mode = 1'b0; bus2.tap_sel = 4'(taps[k]); bus2.div_n = 16'd1;
            step();
            bus2.load = 1'b0;
            for (int i = 0; i < lens[k]; i++) begin
                prev = exp_cnt2;
                step();
                n_checks++; if (bus2.prescaled !== win2(prev, taps[k]) || bus2.count !== exp_cnt2)
                    $display("FAIL sat_tap%0d: got %h/%h want %h/%h", taps[k], bus2.prescaled, bus2.count, win2(prev, taps[k]), exp_cnt2);
                else n_pass++;
            end
        end
        bus2.enable = 1'b0;
    endtask

    task automatic test_divide5();
        logic et;
        bus.load = 1'b1; bus.mode = 1'b1; bus.div_n = 16'd5; bus.tap_sel = 6'd0;
        step();
        bus.load = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            et = ((k % 5) == 0);
            if (et) exp_div = ~exp_div;
            n_checks++; if (bus.tick !== et) $display("FAIL div5_tick_%0d: got %b want %b", k, bus.tick, et); else n_pass++;
            n_checks++; if (bus.div_out !== exp_div || bus.prescaled !== {7'd0, exp_div})
                $display("FAIL div5_out_%0d: got %b/%h want %b/%h", k, bus.div_out, bus.prescaled, exp_div, {7'd0, exp_div});
            else n_pass++;
        end
        n_checks++; if (bus.count !== exp_cnt) $display("FAIL div5_count: got %h want %h", bus.count, exp_cnt); else n_pass++;
    endtask

    task automatic test_enable_gap();
        logic [31:0] held;
        bus.load = 1'b1; bus.mode = 1'b1; bus.div_n = 16'd4;
        step();
        bus.load = 1'b0;
        step(); step();
        n_checks++; if (bus.tick !== 1'b0) $display("FAIL gap_pre_tick: got %b want 0", bus.tick); else n_pass++;
        bus.enable = 1'b0;
        held = exp_cnt;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (bus.tick !== 1'b0 || bus.div_out !== exp_div || bus.count !== held)
                $display("FAIL gap_hold_%0d: got %b/%b/%h want 0/%b/%h", i, bus.tick, bus.div_out, bus.count, exp_div, held);
            else n_pass++;
        end
        bus.enable = 1'b1;
        step();
        n_checks++; if (bus.tick !== 1'b0) $display("FAIL gap_resume1: got %b want 0", bus.tick); else n_pass++;
        step();
        exp_div = ~exp_div;
        n_checks++; if (bus.tick !== 1'b1 || bus.div_out !== exp_div)
            $display("FAIL gap_resume2: got %b/%b want 1/%b", bus.tick, bus.div_out, exp_div); else n_pass++;
        bus.enable = 1'b0;
        step();
        n_checks++; if (bus.tick !== 1'b0 || bus.div_out !== exp_div)
            $display("FAIL gap_no_stretch: got %b/%b want 0/%b", bus.tick, bus.div_out, exp_div); else n_pass++;
        bus.enable = 1'b1;
    endtask

    task automatic test_div1_div0_load_on_tick();
        bus.load = 1'b1; bus.mode = 1'b1; bus.div_n = 16'd1;
        step();
        bus.load = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            exp_div = ~exp_div;
            n_checks++; if (bus.tick !== 1'b1 || bus.div_out !== exp_div)
                $display("FAIL div1_%0d: got %b/%b want 1/%b", k, bus.tick, bus.div_out, exp_div); else n_pass++;
        end
        bus.load = 1'b1; bus.div_n = 16'd0;
        step();
        bus.load = 1'b0;
        n_checks++; if (bus.tick !== 1'b0 || bus.div_out !== exp_div)
            $display("FAIL div0_load: got %b/%b want 0/%b", bus.tick, bus.div_out, exp_div); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++; if (bus.tick !== 1'b0 || bus.div_out !== exp_div)
                $display("FAIL div0_%0d: got %b/%b want 0/%b", k, bus.tick, bus.div_out, exp_div); else n_pass++;
        end
        bus.load = 1'b1; bus.div_n = 16'd3;
        step();
        bus.load = 1'b0;
        step(); step();
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        n_checks++; if (bus.tick !== 1'b0 || bus.div_out !== exp_div)
            $display("FAIL load_on_tick: got %b/%b want 0/%b", bus.tick, bus.div_out, exp_div); else n_pass++;
        step(); step();
        n_checks++; if (bus.tick !== 1'b0) $display("FAIL load_restart_early: got %b want 0", bus.tick); else n_pass++;
        step();
        exp_div = ~exp_div;
        n_checks++; if (bus.tick !== 1'b1 || bus.div_out !== exp_div)
            $display("FAIL load_restart_tick: got %b/%b want 1/%b", bus.tick, bus.div_out, exp_div); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int ticks = 0;
        reset = 1'b1;
        bus.load = 1'b1; bus.mode = 1'b1; bus.tap_sel = 6'd5; bus.div_n = 16'd7; bus.enable = 1'b1;
        step();
        reset = 1'b0;
        bus.load = 1'b0;
        exp_div = 1'b0;
        n_checks++; if (bus.count !== 32'd0 || bus.prescaled !== 8'd0 || bus.tick !== 1'b0 || bus.div_out !== 1'b0)
            $display("FAIL mid_reset_out: got %h/%h/%b/%b want 0/0/0/0", bus.count, bus.prescaled, bus.tick, bus.div_out);
        else n_pass++;
        n_checks++; if (dut.mode_q !== 1'b0 || dut.tap_sel_q !== 6'd22 || dut.div_n_q !== 16'd1)
            $display("FAIL mid_reset_shadow: got %b/%0d/%0d want 0/22/1", dut.mode_q, dut.tap_sel_q, dut.div_n_q); else n_pass++;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.tick !== 1'b0 || bus.prescaled !== 8'd0) ticks++;
        end
        n_checks++; if (ticks != 0) $display("FAIL mid_reset_after: got %0d bad cycles want 0", ticks); else n_pass++;
        n_checks++; if (bus.count !== 32'd100) $display("FAIL mid_reset_count: got %0d want 100", bus.count); else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_default_tap();
        test_tap_window();
        test_saturation();
        test_divide5();
        test_enable_gap();
        test_div1_div0_load_on_tick();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
